// File: rtl/pipelined_csel_adder_pkg.sv
// Shared arithmetic helpers for the pipelined carry-select adder:
// configuration legality and pipeline depth.
package pipelined_csel_adder_pkg;

  function automatic bit csel_cfg_ok(int width, int block);
    return (block >= 1) && (width >= block) && ((width % block) == 0);
  endfunction

  // Falls back to 1 on an illegal configuration so elaboration reaches the error.
  function automatic int csel_nblk(int width, int block);
    return ((block >= 1) && (width >= block)) ? (width / block) : 1;
  endfunction

endpackage

// File: rtl/pipelined_csel_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-select adder.
// The master side supplies operands and consumes results.
interface pipelined_csel_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/pipelined_csel_adder_csel_block.sv
// One carry-select block: two ripple adders (carry-in 0 and 1) and a 2:1 select.
// Also exposes the carry into the block MSB for signed-overflow detection.
module csel_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin_sel,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [BLOCK:0]   r0;
  logic [BLOCK:0]   r1;
  logic [BLOCK-1:0] s0;
  logic [BLOCK-1:0] s1;

  always_comb begin
    r0    = '0;
    r1    = '0;
    s0    = '0;
    s1    = '0;
    r1[0] = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      s0[i]   = a[i] ^ b[i] ^ r0[i];
      r0[i+1] = (a[i] & b[i]) | (r0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ r1[i];
      r1[i+1] = (a[i] & b[i]) | (r1[i] & (a[i] ^ b[i]));
    end
  end

  assign sum     = cin_sel ? s1 : s0;
  assign cout    = cin_sel ? r1[BLOCK] : r0[BLOCK];
  assign msb_cin = cin_sel ? r1[BLOCK-1] : r0[BLOCK-1];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder: one BLOCK-bit slice per stage, whole-pipe stall
// on backpressure, registered sum/carry/overflow outputs.
module pipelined_csel_adder
  import pipelined_csel_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_csel_adder_if.slave io
);

  localparam int NBLK = csel_nblk(WIDTH, BLOCK);

  if (!csel_cfg_ok(WIDTH, BLOCK)) begin : g_cfg_err
    $error("pipelined_csel_adder: WIDTH must be a positive multiple of BLOCK");
  end

  logic             adv;
  logic             vld_p [NBLK];
  logic             cy_p  [NBLK];
  logic [WIDTH-1:0] s_p   [NBLK];
  logic [WIDTH-1:0] a_p   [NBLK];
  logic [WIDTH-1:0] b_p   [NBLK];
  logic             ovf_p;

  logic             prev_vld_c [NBLK];
  logic             prev_cy_c  [NBLK];
  logic [WIDTH-1:0] prev_s_c   [NBLK];
  logic [WIDTH-1:0] prev_a_c   [NBLK];
  logic [WIDTH-1:0] prev_b_c   [NBLK];
  logic [WIDTH-1:0] next_s_c   [NBLK];
  logic [BLOCK-1:0] sum_c      [NBLK];
  logic             cout_c     [NBLK];
  logic             msbc_c     [NBLK];

  function automatic logic [WIDTH-1:0] merge_blk(logic [WIDTH-1:0] acc,
                                                 logic [BLOCK-1:0] blk, int k);
    logic [WIDTH-1:0] r;
    r = acc;
    r[k*BLOCK +: BLOCK] = blk;
    return r;
  endfunction

  // The pipe only moves when the output slot is empty or being drained.
  assign adv          = !vld_p[NBLK-1] | io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = vld_p[NBLK-1];
  assign io.sum       = s_p[NBLK-1];
  assign io.carry_out = cy_p[NBLK-1];
  assign io.overflow  = ovf_p;

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    if (k == 0) begin : g_first
      assign prev_vld_c[k] = io.in_valid;
      assign prev_cy_c[k]  = io.c_in;
      assign prev_s_c[k]   = '0;
      assign prev_a_c[k]   = io.a;
      assign prev_b_c[k]   = io.b;
    end else begin : g_rest
      assign prev_vld_c[k] = vld_p[k-1];
      assign prev_cy_c[k]  = cy_p[k-1];
      assign prev_s_c[k]   = s_p[k-1];
      assign prev_a_c[k]   = a_p[k-1];
      assign prev_b_c[k]   = b_p[k-1];
    end

    csel_block #(.BLOCK(BLOCK)) u_blk (
      .a       (prev_a_c[k][k*BLOCK +: BLOCK]),
      .b       (prev_b_c[k][k*BLOCK +: BLOCK]),
      .cin_sel (prev_cy_c[k]),
      .sum     (sum_c[k]),
      .cout    (cout_c[k]),
      .msb_cin (msbc_c[k])
    );

    assign next_s_c[k] = merge_blk(prev_s_c[k], sum_c[k], k);
  end

  // Stage registers p0..p(NBLK-1); only the last stage's data is reset
  // because it is directly visible on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NBLK; k++) begin
        vld_p[k] <= 1'b0;
      end
      s_p[NBLK-1]  <= '0;
      cy_p[NBLK-1] <= 1'b0;
      ovf_p        <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NBLK; k++) begin
        vld_p[k] <= prev_vld_c[k];
        s_p[k]   <= next_s_c[k];
        cy_p[k]  <= cout_c[k];
        a_p[k]   <= prev_a_c[k];
        b_p[k]   <= prev_b_c[k];
      end
      ovf_p <= msbc_c[NBLK-1] ^ cout_c[NBLK-1];
    end
  end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder (WIDTH=16, BLOCK=4): directed literal cases
// plus randomized traffic scored against an arithmetic reference queue.
module tb_pipelined_csel_adder;

  localparam int W = 16;
  localparam int B = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] exp_q[$];

  pipelined_csel_adder_if #(.WIDTH(W)) bus ();

  pipelined_csel_adder #(.WIDTH(W), .BLOCK(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  function automatic logic [31:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c);
    int unsigned full;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    full = int'(a) + int'(b) + int'(c);
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {14'd0, ov, co, s};
  endfunction

  function automatic logic [31:0] dut_res();
    return {14'd0, bus.overflow, bus.carry_out, bus.sum};
  endfunction

  // Scoreboard: inputs are stable between posedge+1 and the next posedge, so
  // the negedge sees exactly the handshakes the coming edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("in_ready_rule", {31'd0, bus.in_ready},
          {31'd0, (!bus.out_valid) | bus.out_ready});
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_valid actual=1 required=0 at %0t", $time);
        end else begin
          chk("scoreboard", dut_res(), exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.c_in));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [31:0] req);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.c_in      = c;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      bus.in_valid = 1'b0;
      if (i < 4) begin
        chk({name, "_early"}, {31'd0, bus.out_valid}, 32'd0);
      end else begin
        chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk(name, dut_res(), req);
      end
    end
    step();
  endtask

  logic [W-1:0] bp_a [4];
  logic [W-1:0] bp_b [4];
  logic [31:0]  bp_r [4];

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h4321;
    bus.c_in      = 1'b1;
    bus.out_ready = 1'b1;

    // Reset held with in_valid asserted
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_sum", {16'd0, bus.sum}, 32'h0000);
      chk("rst_carry", {31'd0, bus.carry_out}, 32'd0);
      chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    end
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
    end

    // Carry propagation and signed overflow
    run_one("carry_all", 16'hFFFF, 16'h0001, 1'b0, {14'd0, 1'b0, 1'b1, 16'h0000});
    run_one("carry_cin", 16'h0FFF, 16'h0000, 1'b1, {14'd0, 1'b0, 1'b0, 16'h1000});
    run_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, {14'd0, 1'b1, 1'b0, 16'h8000});
    run_one("ovf_neg", 16'h8000, 16'h8000, 1'b0, {14'd0, 1'b1, 1'b1, 16'h0000});

    // Back-to-back on cycles 0,1,2 -> results on cycles 4,5,6
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = (i < 3);
      case (i)
        0: begin bus.a = 16'h1234; bus.b = 16'h1111; bus.c_in = 1'b0; end
        1: begin bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.c_in = 1'b1; end
        2: begin bus.a = 16'hA5A5; bus.b = 16'h5A5A; bus.c_in = 1'b0; end
        default: ;
      endcase
      step();
      chk("b2b_valid", {31'd0, bus.out_valid}, {31'd0, (i >= 3) && (i <= 5)});
      if (i == 3) chk("b2b_r0", dut_res(), {14'd0, 1'b0, 1'b0, 16'h2345});
      if (i == 4) chk("b2b_r1", dut_res(), {14'd0, 1'b0, 1'b1, 16'hFFFF});
      if (i == 5) chk("b2b_r2", dut_res(), {14'd0, 1'b0, 1'b0, 16'hFFFF});
    end

    // Backpressure: fill 4 ops with out_ready low, stall 3 cycles, drain
    bp_a[0] = 16'h0001; bp_b[0] = 16'h0002; bp_r[0] = {14'd0, 1'b0, 1'b0, 16'h0003};
    bp_a[1] = 16'h1000; bp_b[1] = 16'h2000; bp_r[1] = {14'd0, 1'b0, 1'b0, 16'h3000};
    bp_a[2] = 16'h00FF; bp_b[2] = 16'h0001; bp_r[2] = {14'd0, 1'b0, 1'b0, 16'h0100};
    bp_a[3] = 16'hFFF0; bp_b[3] = 16'h0020; bp_r[3] = {14'd0, 1'b0, 1'b1, 16'h0010};
    bus.out_ready = 1'b0;
    bus.c_in      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = bp_a[i];
      bus.b        = bp_b[i];
      step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_hold_res", dut_res(), bp_r[0]);
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_drain_res", dut_res(), bp_r[i]);
      step();
    end
    chk("bp_drain_done", {31'd0, bus.out_valid}, 32'd0);

    // Reset with two ops in flight
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'h4000 + 16'(i);
      bus.b        = 16'h0100;
      step();
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("midrst_dropped", {31'd0, bus.out_valid}, 32'd0);
      step();
    end
    run_one("after_rst", 16'h1111, 16'h2222, 1'b0, {14'd0, 1'b0, 1'b0, 16'h3333});

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.a         = 16'($urandom);
      bus.b         = 16'($urandom);
      bus.c_in      = 1'($urandom);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("rand_queue_empty", exp_q.size(), 32'd0);
    chk("rand_idle", {31'd0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_csel_adder.md
Name: pipelined_csel_adder

Overview:
Parametrised, pipelined carry-select adder for the datapath arithmetic library. It splits a WIDTH-bit add into NBLK = WIDTH/BLOCK blocks and processes one block per pipeline stage. Each block precomputes both carry-in cases and selects one with the registered carry of the previous stage. A valid/ready handshake accepts one operation per cycle with full backpressure, and the block adds signed-overflow reporting.

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of BLOCK
BLOCK, 8, bits per carry-select block; one block per pipeline stage
NBLK, WIDTH/BLOCK, derived localparam; pipeline depth in cycles

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
c_in  in  1  carry in
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  a+b+c_in, modulo 2^WIDTH
carry_out  out  1  unsigned carry out of bit WIDTH-1
overflow  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: when rst_n=0 at a clk edge, all stage valid bits clear and out_valid=0, sum=0, carry_out=0, overflow=0. Any in-flight operation is discarded, not completed.
- Global advance: adv = !out_valid | out_ready. in_ready = adv, combinational.
- Accept: an operation is accepted when in_valid & in_ready.
- Stalls: when adv=0, every stage register holds, including data, carry and valid.
- Stage 0 captures:
  - block-0 sum, computed directly with c_in;
  - block-0 carry out;
  - the remaining upper operand bits;
  - valid = in_valid.
- Stage k (1..NBLK-1):
  - block k computes sum0 (carry-in 0) and sum1 (carry-in 1) from the operand bits carried forward;
  - it selects the sum and carry using the stage k-1 registered carry;
  - it appends the selected sum to the accumulated low sum and forwards the unused operand bits.
- Last stage registers drive sum, carry_out, overflow and out_valid directly; there is no combinational path from a, b or c_in to the outputs.
- Overflow is computed inside the last block: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Latency: exactly NBLK cycles from accept to out_valid=1 when out_ready stays high. Throughput is one result per cycle.
- Ordering: results leave in acceptance order, with no reordering and no drops.
- Bubbles: invalid slots propagate as valid=0. Bubbles do not collapse under stall, because the whole pipe freezes.
- Output stability: while out_valid=1 and out_ready=0, sum, carry_out and overflow hold stable.
- NBLK=1: degenerates to a single registered adder stage with latency 1.
- Elaboration: if WIDTH%BLOCK≠0 or BLOCK<1, raise an elaboration-time error.

Decomposition:
- Shared arith package: the BLOCK/WIDTH legality check function and an NBLK calculation helper.
- No typedefs are needed.
- One sub-module: csel_block, parametrised by BLOCK. It is combinational.
  - Inputs: a, b, cin_sel.
  - Outputs: sum, cout, and the MSB carry-in (used for overflow).
  - Internally it holds two ripple adders plus a 2:1 select, and it is instantiated once per stage.

Test Plan:
All scenarios use WIDTH=16, BLOCK=4, so latency is 4.
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, sum=0x0000, carry_out=0, overflow=0 throughout; then release with in_valid=0 -> out_valid stays 0.
- Carry across all blocks: a=0xFFFF, b=0x0001, c_in=0, out_ready=1 -> 4 cycles later sum=0x0000, carry_out=1, overflow=0. Also a=0x0FFF, b=0x0000, c_in=1 -> sum=0x1000, carry_out=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, carry_out=0, overflow=1. Also a=0x8000, b=0x8000 -> sum=0x0000, carry_out=1, overflow=1.
- Back-to-back: push 0x1234+0x1111, then 0xFFFF+0xFFFF with c_in=1, then 0xA5A5+0x5A5A, on consecutive cycles -> out_valid high on cycles 4, 5, 6 with sum=0x2345, then 0xFFFF with cout=1, then 0xFFFF with cout=0.
- Backpressure: fill the pipe with 4 ops, drop out_ready for 3 cycles -> in_ready=0 and outputs stable for those 3 cycles; raise out_ready -> all 4 results delivered in order, none lost or duplicated.
- Reset mid-operation: accept 2 ops, assert rst_n=0 at cycle 2 -> out_valid never rises for those ops; a new op accepted after reset returns its correct sum after 4 cycles.
